// File: rtl/pc_pkg.sv
// Shared types for the MIPS fetch-stage program-counter unit.
package pc_pkg;

    localparam int unsigned INSTR_BYTES_DEF = 4;
    localparam int unsigned ALIGN_BITS      = $clog2(INSTR_BYTES_DEF);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HELD  = 2'd2
    } pc_state_e;

    // Ordered so that a numerically larger value means a stronger redirect
    typedef enum logic [1:0] {
        PRIO_NONE   = 2'd0,
        PRIO_BRANCH = 2'd1,
        PRIO_JUMP   = 2'd2,
        PRIO_EXC    = 2'd3
    } pc_prio_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: live requests (exc > jump > branch) against a pending entry.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                exc_req,
    input  logic [PC_WIDTH-1:0] exc_vector,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  pc_prio_e            pend_prio,
    input  logic [PC_WIDTH-1:0] pend_target,
    input  logic                live_first,
    output pc_prio_e            win_prio,
    output logic [PC_WIDTH-1:0] win_target
);

    pc_prio_e            w_live_prio;
    logic [PC_WIDTH-1:0] w_live_target;

    // Fixed-priority pick among the live requests
    always_comb begin
        w_live_prio   = PRIO_NONE;
        w_live_target = '0;
        if (exc_req) begin
            w_live_prio   = PRIO_EXC;
            w_live_target = exc_vector;
        end else if (jump) begin
            w_live_prio   = PRIO_JUMP;
            w_live_target = jump_target;
        end else if (branch_taken) begin
            w_live_prio   = PRIO_BRANCH;
            w_live_target = branch_target;
        end
    end

    // On release any live request beats the pending one; while stalled, equal-or-higher replaces it
    always_comb begin
        win_prio   = pend_prio;
        win_target = pend_target;
        if (w_live_prio != PRIO_NONE) begin
            if (live_first || (w_live_prio >= pend_prio)) begin
                win_prio   = w_live_prio;
                win_target = w_live_target;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, prioritised redirects, stall with held redirect.
// Optional feature macro: PC_MISALIGN_CHK_EN (trap on misaligned targets instead of masking).
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          INSTR_BYTES  = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(32'h0000_0000),
    parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'(32'h0000_0080)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                exc_req,
    input  logic [PC_WIDTH-1:0] exc_vector,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus,
    output logic                pc_valid,
    output logic                redirect_pending
`ifdef PC_MISALIGN_CHK_EN
    ,
    output logic                misalign_fault,
    output logic [PC_WIDTH-1:0] fault_addr
`endif
);

    localparam int unsigned ALIGN_W =
        (INSTR_BYTES == INSTR_BYTES_DEF) ? ALIGN_BITS : $clog2(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'((64'd1 << ALIGN_W) - 64'd1);

    pc_state_e           r_state,  w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc,     w_pc_nxt;
    logic                r_valid,  w_valid_nxt;
    logic [PC_WIDTH-1:0] r_pend_target, w_pend_target_nxt;
    pc_prio_e            r_pend_prio,   w_pend_prio_nxt;
    logic                r_pend_flag,   w_pend_flag_nxt;
    pc_prio_e            w_win_prio;
    logic [PC_WIDTH-1:0] w_win_target;
    logic [PC_WIDTH-1:0] w_pc_plus;
    logic                w_live_first;
    logic                w_load;

`ifdef PC_MISALIGN_CHK_EN
    logic                r_fault,      w_fault_nxt;
    logic [PC_WIDTH-1:0] r_fault_addr, w_fault_addr_nxt;
`else
    logic                w_unused_trap;
    assign w_unused_trap = ^TRAP_VECTOR;
`endif

    assign w_pc_plus    = r_pc + PC_WIDTH'(INSTR_BYTES);
    assign w_live_first = (r_state == ST_HELD) && !stall;

    pc_redirect_arb #(
        .PC_WIDTH (PC_WIDTH)
    ) u_arb (
        .exc_req       (exc_req),
        .exc_vector    (exc_vector),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pend_prio     (r_pend_prio),
        .pend_target   (r_pend_target),
        .live_first    (w_live_first),
        .win_prio      (w_win_prio),
        .win_target    (w_win_target)
    );

    // Next-state and next-register values
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_valid_nxt       = r_valid;
        w_pend_target_nxt = r_pend_target;
        w_pend_prio_nxt   = r_pend_prio;
        w_pend_flag_nxt   = r_pend_flag;
        w_load            = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
        w_fault_nxt       = 1'b0;
        w_fault_addr_nxt  = r_fault_addr;
`endif
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_RUN;
                w_valid_nxt = 1'b1;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (w_win_prio != PRIO_NONE) begin
                        w_load = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_plus;
                    end
                end else if (w_win_prio != PRIO_NONE) begin
                    w_pend_target_nxt = w_win_target;
                    w_pend_prio_nxt   = w_win_prio;
                    w_pend_flag_nxt   = 1'b1;
                    w_state_nxt       = ST_HELD;
                end
            end
            ST_HELD: begin
                if (stall) begin
                    w_pend_target_nxt = w_win_target;
                    w_pend_prio_nxt   = w_win_prio;
                end else begin
                    w_load            = 1'b1;
                    w_pend_target_nxt = '0;
                    w_pend_prio_nxt   = PRIO_NONE;
                    w_pend_flag_nxt   = 1'b0;
                    w_state_nxt       = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
        // Load the winning target, trapping or masking low bits as configured
        if (w_load) begin
`ifdef PC_MISALIGN_CHK_EN
            if ((w_win_target & ALIGN_MASK) != '0) begin
                w_pc_nxt         = TRAP_VECTOR;
                w_fault_nxt      = 1'b1;
                w_fault_addr_nxt = w_win_target;
            end else begin
                w_pc_nxt = w_win_target;
            end
`else
            w_pc_nxt = w_win_target & ~ALIGN_MASK;
`endif
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RESET;
            r_pc          <= RESET_VECTOR;
            r_valid       <= 1'b0;
            r_pend_target <= '0;
            r_pend_prio   <= PRIO_NONE;
            r_pend_flag   <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
            r_fault       <= 1'b0;
            r_fault_addr  <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_valid       <= w_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_pend_prio   <= w_pend_prio_nxt;
            r_pend_flag   <= w_pend_flag_nxt;
`ifdef PC_MISALIGN_CHK_EN
            r_fault       <= w_fault_nxt;
            r_fault_addr  <= w_fault_addr_nxt;
`endif
        end
    end

    assign pc               = r_pc;
    assign pc_plus          = w_pc_plus;
    assign pc_valid         = r_valid;
    assign redirect_pending = r_pend_flag;
`ifdef PC_MISALIGN_CHK_EN
    assign misalign_fault   = r_fault;
    assign fault_addr       = r_fault_addr;
`endif

endmodule
